// File: rtl/sq_pkg.sv
// Shared constants and helpers for the squaring core and its downstream consumers.
package sq_pkg;

  // Width of the unsigned sample fed to the squaring core.
  localparam int N_W = 4;

  // Width of the squared result; (2**N_W - 1)**2 = 225 fits in 8 bits.
  localparam int N2_W = 8;

  // Largest value the squaring core can ever produce.
  localparam logic [N2_W-1:0] N2_MAX = 8'd225;

  // Larger of two squared samples.
  function automatic logic [N2_W-1:0] n2_max(
    input logic [N2_W-1:0] a,
    input logic [N2_W-1:0] b
  );
    logic [N2_W-1:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

  // Counter width needed to hold 0..window-1 (never narrower than one bit).
  function automatic int cnt_width(input int window);
    int w;
    if (window > 1) begin
      w = $clog2(window);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sq_window_ctr.sv
// Window sample counter: counts accepted samples 0..WINDOW-1 and flags the
// increment that completes the window (the counter wraps to 0 on that edge).
module sq_window_ctr #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == TC);

  // Strobe on the increment that closes the window.
  assign last = inc && w_tc;
  assign cnt  = r_cnt;

  // Count register: clear has priority, wrap to zero on the closing increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc) begin
      if (w_tc) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/sq_window_acc.sv
// Windowed sum / max of the squared-sample stream with a one-deep
// valid/ready result register. The last sample of a window is held off
// while the previous result is still waiting to be taken.
module sq_window_acc
  import sq_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int SUM_W  = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N2_W-1:0]  n2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic [N2_W-1:0]  max_n2
);

  localparam int               CNT_W = cnt_width(WINDOW);
  localparam logic [CNT_W-1:0] TC    = CNT_W'(WINDOW - 1);

  logic [SUM_W-1:0] r_acc;
  logic [N2_W-1:0]  r_mx;
  logic [SUM_W-1:0] r_sum;
  logic [N2_W-1:0]  r_max_n2;
  logic             r_out_valid;

  logic [CNT_W-1:0] w_cnt;
  logic             w_close;
  logic             w_accept;
  logic [SUM_W-1:0] w_acc_next;
  logic [N2_W-1:0]  w_mx_next;

  // in_ready depends only on clr and registered state, never on out_ready.
  assign in_ready = !clr && !((w_cnt == TC) && r_out_valid);
  assign w_accept = in_valid && in_ready;

  // Running sum and max including the sample offered this cycle.
  assign w_acc_next = r_acc + SUM_W'(n2);
  assign w_mx_next  = n2_max(r_mx, n2);

  sq_window_ctr #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_ctr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (w_accept),
    .clr  (clr),
    .cnt  (w_cnt),
    .last (w_close)
  );

  // Partial-window accumulator and max: restart on clr or on window close.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= {SUM_W{1'b0}};
      r_mx  <= {N2_W{1'b0}};
    end else if (clr) begin
      r_acc <= {SUM_W{1'b0}};
      r_mx  <= {N2_W{1'b0}};
    end else if (w_close) begin
      r_acc <= {SUM_W{1'b0}};
      r_mx  <= {N2_W{1'b0}};
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_mx  <= w_mx_next;
    end else begin
      r_acc <= r_acc;
      r_mx  <= r_mx;
    end
  end

  // Result register: load on window close, drop valid on handshake. The two
  // cannot coincide because the closing sample is refused while valid is set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sum       <= {SUM_W{1'b0}};
      r_max_n2    <= {N2_W{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_close) begin
      r_sum       <= w_acc_next;
      r_max_n2    <= w_mx_next;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_sum       <= r_sum;
      r_max_n2    <= r_max_n2;
      r_out_valid <= 1'b0;
    end else begin
      r_sum       <= r_sum;
      r_max_n2    <= r_max_n2;
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign max_n2    = r_max_n2;

endmodule

// File: tb/tb_sq_window_acc.sv
// Directed self-checking bench for sq_window_acc (WINDOW=16, SUM_W=12).
module tb_sq_window_acc;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  n2;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] sum;
  logic [7:0]  max_n2;

  int pass_cnt;
  int total_cnt;

  sq_window_acc #(
    .WINDOW (16),
    .SUM_W  (12)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n2        (n2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .max_n2    (max_n2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one sample for one clock; inputs change 1 time unit after the edge.
  task automatic push(input logic [7:0] v);
    in_valid = 1'b1;
    n2       = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; n2 = 8'd0; out_ready = 1'b0;
    idle(2);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (sum !== 12'd0 || max_n2 !== 8'd0) $display("FAIL reset_data: got sum=%0d max=%0d want 0/0", sum, max_n2);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic test_constant;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) push(8'd9);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL const_early: got out_valid=%b want 0 after 15 samples", out_valid);
    else pass_cnt++;
    push(8'd9);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd144 || max_n2 !== 8'd9)
      $display("FAIL const_result: got v=%b sum=%0d max=%0d want 1/144/9", out_valid, sum, max_n2);
    else pass_cnt++;
    idle(1);
    total_cnt++;
    if (out_valid !== 1'b0 || sum !== 12'd144)
      $display("FAIL const_consumed: got v=%b sum=%0d want 0/144", out_valid, sum);
    else pass_cnt++;
  endtask

  task automatic test_full_scale;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'd225);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd3600 || max_n2 !== 8'd225)
      $display("FAIL full_scale: got v=%b sum=%0d max=%0d want 1/3600/225", out_valid, sum, max_n2);
    else pass_cnt++;
    idle(1);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'd3);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd48 || max_n2 !== 8'd3)
      $display("FAIL bp_first: got v=%b sum=%0d max=%0d want 1/48/3", out_valid, sum, max_n2);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) push(8'd5);
    in_valid = 1'b1;
    n2       = 8'd100;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_stall: got in_ready=%b want 0 at cnt 15", in_ready);
    else pass_cnt++;
    idle(3);
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 12'd48)
      $display("FAIL bp_hold: got rdy=%b v=%b sum=%0d want 0/1/48", in_ready, out_valid, sum);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_no_comb_path: got in_ready=%b want 0", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_handshake: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd175 || max_n2 !== 8'd100)
      $display("FAIL bp_second: got v=%b sum=%0d max=%0d want 1/175/100", out_valid, sum, max_n2);
    else pass_cnt++;
    out_ready = 1'b1;
    idle(1);
  endtask

  task automatic test_restart;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'd4);
    clr      = 1'b1;
    in_valid = 1'b1;
    n2       = 8'd50;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL clr_in_ready: got %b want 0", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) push(8'd1);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL clr_count: got out_valid=%b want 0 after 15 samples", out_valid);
    else pass_cnt++;
    push(8'd1);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd16 || max_n2 !== 8'd1)
      $display("FAIL clr_result: got v=%b sum=%0d max=%0d want 1/16/1", out_valid, sum, max_n2);
    else pass_cnt++;
    idle(1);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'd2);
    for (int i = 0; i < 7; i++) push(8'd9);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd32)
      $display("FAIL rst_pending: got v=%b sum=%0d want 1/32", out_valid, sum);
    else pass_cnt++;
    rstn = 1'b0;
    #2;
    total_cnt++;
    if (out_valid !== 1'b0 || sum !== 12'd0 || max_n2 !== 8'd0 || in_ready !== 1'b1)
      $display("FAIL rst_async: got v=%b sum=%0d max=%0d rdy=%b want 0/0/0/1", out_valid, sum, max_n2, in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) push(8'd6);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_count: got out_valid=%b want 0 after 15 samples", out_valid);
    else pass_cnt++;
    push(8'd6);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd96 || max_n2 !== 8'd6)
      $display("FAIL rst_result: got v=%b sum=%0d max=%0d want 1/96/6", out_valid, sum, max_n2);
    else pass_cnt++;
    idle(1);
  endtask

  task automatic test_ramp;
    logic [7:0] k;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      k = 8'(i);
      push(8'(k * k));
    end
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== 12'd1240 || max_n2 !== 8'd225)
      $display("FAIL ramp: got v=%b sum=%0d max=%0d want 1/1240/225", out_valid, sum, max_n2);
    else pass_cnt++;
    idle(1);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_constant();
    test_full_scale();
    test_backpressure();
    test_restart();
    test_reset_mid();
    test_ramp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sq_window_acc.md
# sq_window_acc

Downstream consumer of the squaring core's `n2` result stream. Accumulates a fixed window of `WINDOW` squared samples into a sum, tracks the window maximum, and presents both on a one-deep valid/ready output register. Its input is the core's registered `n2` plus a valid qualifier from the stage driving `n`. It feeds the statistics/readout logic.

## Interface
- `WINDOW`, default 16: samples per window. Range 2..256.
- `SUM_W`, default 12: width of `sum`. Must be ≥ 8 + clog2(`WINDOW`); the default covers 16 × 225 = 3600.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous restart of the current window.
- `in_valid` input 1: `n2` holds a valid sample.
- `in_ready` output 1: the block can accept a sample this cycle.
- `n2` input 8: squared sample, 0..225.
- `out_valid` output 1: `sum`/`max_n2` hold a completed window.
- `out_ready` input 1: the consumer takes the result.
- `sum` output SUM_W: sum of the window's `n2` values.
- `max_n2` output 8: largest `n2` in the window.

## Operation
- **Reset values:** `cnt`=0, `acc`=0, `mx`=0, `out_valid`=0, `sum`=0, `max_n2`=0. `in_ready` resets to 1.
- **Accept:** a sample is accepted when `in_valid && in_ready`. On accept:
  - `acc += n2`, zero-extended to SUM_W.
  - `mx = max(mx, n2)`.
  - `cnt++`.
- **Window close:** on accept with `cnt==WINDOW-1`:
  - `sum <= acc + n2`; `max_n2 <= max(mx, n2)`; `out_valid <= 1`.
  - `acc`, `mx`, `cnt` return to 0 in the same edge.
- **Output handshake:** `out_valid` falls on the edge where `out_valid && out_ready`. `sum`/`max_n2` hold their values until the next window close.
- **Backpressure:** `in_ready = !clr && !(cnt==WINDOW-1 && out_valid)`.
  - This is registered state only; there is no combinational path from `out_ready` to `in_ready`.
  - The last sample of a window is refused while the previous result is still pending. Samples 0..WINDOW-2 are always accepted.
- **Simultaneous events:**
  - `out_ready` handshake and a window close in the same cycle cannot occur, because `in_ready` is low then.
  - Consequence: a one-cycle bubble whenever the previous result is consumed at the exact closing cycle.
  - `clr` with `in_valid`: `in_ready`=0, the sample is not accepted, and `acc`/`mx`/`cnt` are cleared.
  - `clr` never affects a pending output.
- **Arithmetic:** no saturation. The SUM_W constraint guarantees no overflow.
- **Reset mid-window:** all partial state and any pending output are lost. `out_valid` drops immediately on assertion of `rstn`=0.

## Timing
- Latency: last sample accepted at edge t → `out_valid`=1 and `sum` valid from t until the handshake.
- Throughput: one sample per cycle while `out_ready` is held high with no coincidences. Worst case is one stall cycle per window.
- `in_ready` and `out_valid` are registered or derived from registered state only.

## Structure
- Shared package `sq_pkg` holds the constants `N_W`=4, `N2_W`=8 and `N2_MAX`=225. The squaring core and this block both import it.
- The window counter with terminal-count flag is a natural sub-module: `sq_window_ctr` (inputs `inc`, `clr`; outputs `cnt`, `last`).
- The datapath and handshake stay in `sq_window_acc`.

## Test plan
- **Constant input:** `n2`=9 for 16 consecutive cycles with `out_ready`=1 → `out_valid` one cycle after the 16th accept, `sum`=144, `max_n2`=9.
- **Full-scale window:** 16 samples of 225 → `sum`=3600, `max_n2`=225, no overflow.
- **Backpressure:** `out_ready`=0 over two windows → `in_ready` drops at `cnt`=15 of window 2 and stays low. First result (`sum`) holds. Raising `out_ready` → handshake, then the 16th sample is accepted the following cycle.
- **Restart:** `clr` pulse after 5 samples of 4 → `acc`/`cnt` cleared, sample in the `clr` cycle not accepted. The next 16 samples of 1 → `sum`=16, `max_n2`=1.
- **Reset mid-operation:** `rstn` low with a result pending and `cnt`=7 → all outputs 0 and `in_ready`=1 after release. The next full window sums correctly from zero.
- **Ramp:** `n2` = k² for k=0..15 → `sum`=1240, `max_n2`=225.
